// File: rtl/wb_port_mem_responder_if.sv
// Port-arbiter access channel plus pipelined memory backend channel seen by
// wb_port_mem_responder; slave is the responder side, master the environment.
interface wb_port_mem_responder_if #(
    parameter int MEM_ADR_WIDTH = 24
);
    logic                     acc_i;
    logic                     we_i;
    logic [31:0]              adr_i;
    logic [31:0]              dat_i;
    logic [3:0]               sel_i;
    logic [3:0]               buf_width_i;
    logic                     ack_o;
    logic [31:0]              adr_o;
    logic [31:0]              dat_o;
    logic                     idle_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [MEM_ADR_WIDTH-1:0] mem_adr_o;
    logic [31:0]              mem_dat_o;
    logic [3:0]               mem_sel_o;
    logic                     mem_gnt_i;
    logic                     mem_rvalid_i;
    logic [31:0]              mem_rdata_i;

    modport slave (
        input  acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ack_o, adr_o, dat_o, idle_o,
        output mem_req_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o
    );

    modport master (
        output acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ack_o, adr_o, dat_o, idle_o,
        input  mem_req_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o
    );
endinterface

// File: rtl/wb_port_mem_responder.sv
// Executes one arbiter port access at a time against a pipelined req/gnt/rvalid
// memory: single-word writes, 2^bw word read bursts. MEM_RESPONDER_CWF_EN selects critical-word-first.
module wb_port_mem_responder #(
    parameter int MEM_ADR_WIDTH   = 24,
    parameter int MAX_BUF_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst_n,
    wb_port_mem_responder_if.slave bus
);
    localparam int CNT_W = MAX_BUF_WIDTH + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [31:0]      adr_r;
    logic [3:0]       bw_r;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] iss_r;
    logic [CNT_W-1:0] rsp_r;
    logic [OUT_W-1:0] out_r;

    logic             gnt_fire_s;
    logic [CNT_W-1:0] iss_nx_s;
    logic [OUT_W-1:0] out_nx_s;
    logic             req_nx_s;
    logic [3:0]       bw_in_s;

    function automatic logic [3:0] clamp_bw(input logic [3:0] bw);
        if (bw > 4'(MAX_BUF_WIDTH)) begin
            return 4'(MAX_BUF_WIDTH);
        end else begin
            return bw;
        end
    endfunction

    // Word address of the k-th word of the aligned 2^bw block containing first_word.
    function automatic logic [29:0] burst_word(input logic [29:0] first_word,
                                               input logic [3:0] bw,
                                               input logic [CNT_W-1:0] k);
        logic [29:0] mask;
        logic [29:0] start;
        mask = (30'd1 << bw) - 30'd1;
`ifdef MEM_RESPONDER_CWF_EN
        start = first_word & mask;
`else
        start = 30'd0;
`endif
        return (first_word & ~mask) | ((start + 30'(k)) & mask);
    endfunction

    // Next issue/outstanding counts and whether another read request may go out.
    always_comb begin
        bw_in_s    = clamp_bw(bus.buf_width_i);
        gnt_fire_s = bus.mem_req_o & bus.mem_gnt_i;
        iss_nx_s   = iss_r + CNT_W'(gnt_fire_s);
        if (gnt_fire_s && !bus.mem_rvalid_i) begin
            out_nx_s = out_r + OUT_ONE;
        end else if (!gnt_fire_s && bus.mem_rvalid_i && (out_r != {OUT_W{1'b0}})) begin
            out_nx_s = out_r - OUT_ONE;
        end else begin
            out_nx_s = out_r;
        end
        req_nx_s = (iss_nx_s < len_r) && (out_nx_s < OUT_MAX);
    end

    // Access FSM with registered bus and backend outputs.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_r       <= IDLE;
            adr_r         <= 32'd0;
            bw_r          <= 4'd0;
            len_r         <= {CNT_W{1'b0}};
            iss_r         <= {CNT_W{1'b0}};
            rsp_r         <= {CNT_W{1'b0}};
            out_r         <= {OUT_W{1'b0}};
            bus.ack_o     <= 1'b0;
            bus.adr_o     <= 32'd0;
            bus.dat_o     <= 32'd0;
            bus.idle_o    <= 1'b1;
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.mem_adr_o <= {MEM_ADR_WIDTH{1'b0}};
            bus.mem_dat_o <= 32'd0;
            bus.mem_sel_o <= 4'd0;
        end else begin
            bus.ack_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.acc_i) begin
                        adr_r         <= bus.adr_i;
                        bw_r          <= bw_in_s;
                        len_r         <= CNT_ONE << bw_in_s;
                        iss_r         <= {CNT_W{1'b0}};
                        rsp_r         <= {CNT_W{1'b0}};
                        out_r         <= {OUT_W{1'b0}};
                        bus.idle_o    <= 1'b0;
                        bus.mem_req_o <= 1'b1;
                        if (bus.we_i) begin
                            state_r       <= WRITE;
                            bus.mem_we_o  <= 1'b1;
                            bus.mem_adr_o <= bus.adr_i[MEM_ADR_WIDTH+1:2];
                            bus.mem_dat_o <= bus.dat_i;
                            bus.mem_sel_o <= bus.sel_i;
                        end else begin
                            state_r       <= READ;
                            bus.mem_we_o  <= 1'b0;
                            bus.mem_adr_o <= MEM_ADR_WIDTH'(burst_word(bus.adr_i[31:2], bw_in_s,
                                                                       {CNT_W{1'b0}}));
                            bus.mem_dat_o <= 32'd0;
                            bus.mem_sel_o <= 4'hf;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_gnt_i) begin
                        bus.mem_req_o <= 1'b0;
                        bus.mem_we_o  <= 1'b0;
                        bus.ack_o     <= 1'b1;
                        bus.adr_o     <= adr_r;
                        state_r       <= DONE;
                    end
                end
                READ: begin
                    iss_r         <= iss_nx_s;
                    out_r         <= out_nx_s;
                    bus.mem_req_o <= req_nx_s;
                    bus.mem_adr_o <= MEM_ADR_WIDTH'(burst_word(adr_r[31:2], bw_r, iss_nx_s));
                    if (bus.mem_rvalid_i) begin
                        bus.ack_o <= 1'b1;
                        bus.dat_o <= bus.mem_rdata_i;
                        bus.adr_o <= {burst_word(adr_r[31:2], bw_r, rsp_r), 2'b00};
                        rsp_r     <= rsp_r + CNT_ONE;
                        if (rsp_r == (len_r - CNT_ONE)) begin
                            bus.mem_req_o <= 1'b0;
                            state_r       <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Wait for the initiator to drop acc so a stale request cannot re-trigger.
                    if (!bus.acc_i) begin
                        bus.idle_o <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    bus.mem_req_o <= 1'b0;
                    bus.mem_we_o  <= 1'b0;
                    bus.idle_o    <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end
endmodule
